// File: rtl/param_rs.sv
// Reservation station with a CDB wakeup path, oldest-ready select and a registered issue slot.
// Parameters: DEPTH entries (power of two, >=2), NCDB broadcast ports, DATA_W operand/imm width,
//   TAG_W tag width (tag 0 = operand present), OP_W opcode width, NAME_W dest-name width.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   rdy             global enable; when low all state holds (flush included)
//   flush           synchronous kill of all entries and the issue slot
//   cdb_valid/tag/data  NCDB result broadcasts, port k at [k*W +: W]
//   alloc_*         dispatch request/payload; alloc_ready when any entry is empty
//   issue_*         registered issue slot with valid/ready handshake
//   count           number of occupied entries (issue slot excluded)
module param_rs #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned NCDB   = 2,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned NAME_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic [NCDB-1:0]          cdb_valid,
  input  logic [NCDB*TAG_W-1:0]    cdb_tag,
  input  logic [NCDB*DATA_W-1:0]   cdb_data,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [DATA_W-1:0]        alloc_data_o,
  input  logic [DATA_W-1:0]        alloc_data_t,
  input  logic [TAG_W-1:0]         alloc_tag_o,
  input  logic [TAG_W-1:0]         alloc_tag_t,
  input  logic [TAG_W-1:0]         alloc_tag_w,
  input  logic [NAME_W-1:0]        alloc_name_w,
  input  logic [OP_W-1:0]          alloc_op,
  input  logic [DATA_W-1:0]        alloc_imm,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [DATA_W-1:0]        issue_data_o,
  output logic [DATA_W-1:0]        issue_data_t,
  output logic [DATA_W-1:0]        issue_imm,
  output logic [OP_W-1:0]          issue_op,
  output logic [NAME_W-1:0]        issue_name_w,
  output logic [TAG_W-1:0]         issue_tag_w,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  // Returns {tag, data} after applying this cycle's broadcasts; lowest port wins on duplicates.
  function automatic logic [TAG_W+DATA_W-1:0] fwd(
    input logic [TAG_W-1:0]        tag,
    input logic [DATA_W-1:0]       data,
    input logic [NCDB-1:0]         v,
    input logic [NCDB*TAG_W-1:0]   t,
    input logic [NCDB*DATA_W-1:0]  d
  );
    logic [TAG_W+DATA_W-1:0] r;
    r = {tag, data};
    if (tag != '0) begin
      for (int k = NCDB - 1; k >= 0; k--) begin
        if (v[k] && (t[k*TAG_W +: TAG_W] == tag)) r = {{TAG_W{1'b0}}, d[k*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_o_q [DEPTH];
  logic [DATA_W-1:0] data_t_q [DEPTH];
  logic [TAG_W-1:0]  tag_o_q  [DEPTH];
  logic [TAG_W-1:0]  tag_t_q  [DEPTH];
  logic [TAG_W-1:0]  tag_w_q  [DEPTH];
  logic [NAME_W-1:0] name_w_q [DEPTH];
  logic [OP_W-1:0]   op_q     [DEPTH];
  logic [DATA_W-1:0] imm_q    [DEPTH];
  // older_q[j][i] set means entry j was allocated before entry i.
  logic [DEPTH-1:0]  older_q  [DEPTH];

  logic [DATA_W-1:0] fdata_o [DEPTH];
  logic [DATA_W-1:0] fdata_t [DEPTH];
  logic [TAG_W-1:0]  ftag_o  [DEPTH];
  logic [TAG_W-1:0]  ftag_t  [DEPTH];
  logic [DEPTH-1:0]  ready;
  logic [DEPTH-1:0]  sel;
  logic [IW-1:0]     sel_idx;
  logic              any_ready;
  logic [IW-1:0]     alloc_idx;
  logic              alloc_fire;
  logic              issue_load;
  logic [DATA_W-1:0] adata_o, adata_t;
  logic [TAG_W-1:0]  atag_o, atag_t;
  logic [CW-1:0]     cnt;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      {ftag_o[i], fdata_o[i]} = fwd(tag_o_q[i], data_o_q[i], cdb_valid, cdb_tag, cdb_data);
      {ftag_t[i], fdata_t[i]} = fwd(tag_t_q[i], data_t_q[i], cdb_valid, cdb_tag, cdb_data);
      ready[i] = valid_q[i] && (ftag_o[i] == '0) && (ftag_t[i] == '0);
    end
    {atag_o, adata_o} = fwd(alloc_tag_o, alloc_data_o, cdb_valid, cdb_tag, cdb_data);
    {atag_t, adata_t} = fwd(alloc_tag_t, alloc_data_t, cdb_valid, cdb_tag, cdb_data);
  end

  // Oldest-ready select: an entry wins when no other ready entry is older than it.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = ready[i];
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && ready[j] && older_q[j][i]) sel[i] = 1'b0;
      end
      if (sel[i]) sel_idx = IW'(i);
    end
    any_ready = |ready;
  end

  always_comb begin
    alloc_idx = '0;
    cnt       = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = IW'(i);
      cnt = cnt + CW'(valid_q[i]);
    end
  end

  assign count       = cnt;
  assign alloc_ready = ~&valid_q;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign issue_load  = !issue_valid || issue_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      issue_valid  <= 1'b0;
      issue_data_o <= '0;
      issue_data_t <= '0;
      issue_imm    <= '0;
      issue_op     <= '0;
      issue_name_w <= '0;
      issue_tag_w  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_o_q[i] <= '0;
        data_t_q[i] <= '0;
        tag_o_q[i]  <= '0;
        tag_t_q[i]  <= '0;
        tag_w_q[i]  <= '0;
        name_w_q[i] <= '0;
        op_q[i]     <= '0;
        imm_q[i]    <= '0;
        older_q[i]  <= '0;
      end
    end else if (rdy) begin
      if (flush) begin
        valid_q     <= '0;
        issue_valid <= 1'b0;
      end else begin
        // Wakeup: capture broadcasts into every entry (harmless for empty ones).
        for (int i = 0; i < DEPTH; i++) begin
          data_o_q[i] <= fdata_o[i];
          data_t_q[i] <= fdata_t[i];
          tag_o_q[i]  <= ftag_o[i];
          tag_t_q[i]  <= ftag_t[i];
        end
        if (issue_load) begin
          issue_valid <= any_ready;
          if (any_ready) begin
            valid_q[sel_idx] <= 1'b0;
            issue_data_o     <= fdata_o[sel_idx];
            issue_data_t     <= fdata_t[sel_idx];
            issue_imm        <= imm_q[sel_idx];
            issue_op         <= op_q[sel_idx];
            issue_name_w     <= name_w_q[sel_idx];
            issue_tag_w      <= tag_w_q[sel_idx];
          end
        end
        // alloc_idx was empty at the start of the cycle, so it never collides with sel_idx.
        if (alloc_fire) begin
          valid_q[alloc_idx]  <= 1'b1;
          data_o_q[alloc_idx] <= adata_o;
          data_t_q[alloc_idx] <= adata_t;
          tag_o_q[alloc_idx]  <= atag_o;
          tag_t_q[alloc_idx]  <= atag_t;
          tag_w_q[alloc_idx]  <= alloc_tag_w;
          name_w_q[alloc_idx] <= alloc_name_w;
          op_q[alloc_idx]     <= alloc_op;
          imm_q[alloc_idx]    <= alloc_imm;
          // New entry is younger than everything; stale bits of empty entries are never read.
          older_q[alloc_idx]  <= '0;
          for (int j = 0; j < DEPTH; j++) begin
            if (j != int'(alloc_idx)) older_q[j][alloc_idx] <= 1'b1;
          end
        end
      end
    end
  end

endmodule
